// File: rtl/patterner_cfg_ctrl.sv
// Shadow/active configuration for the patterner array: register writes land in shadow copies,
// apply_req commits them atomically after a quiet window (or timeout), then triggers are blanked.
module patterner_cfg_ctrl #(
    parameter int          NMASK     = 4,
    parameter int          QUIET_CYC = 4,
    parameter int          TIMEOUT   = 255,
    parameter logic [16:0] DEF_THR   = 17'h0_4893
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr,
    input  logic [3:0]            cfg_addr,
    input  logic [27:0]           cfg_wdata,
    output logic                  cfg_ack,
    output logic                  cfg_err,
    input  logic                  apply_req,
    output logic                  apply_busy,
    output logic                  apply_done,
    input  logic                  quiet,
    output logic                  forced,
    output logic                  patt_blank,
    output logic [2:0]            drifttime,
    output logic [2:0]            pretrig,
    output logic [2:0]            trig,
    output logic [2:0]            acc_pretrig,
    output logic [2:0]            acc_trig,
    output logic [1:0]            trig_mode,
    output logic [28*NMASK-1:0]   collmask
);

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT, BLANK} state_t;

    localparam logic [3:0] QC       = 4'(QUIET_CYC);
    localparam logic [7:0] TO       = 8'(TIMEOUT);
    localparam logic [3:0] MASK_TOP = 4'(NMASK);

    state_t              state, state_n;
    logic [16:0]         thr_sh, thr_act;
    logic [28*NMASK-1:0] mask_sh, mask_act;
    logic [3:0]          qcnt, qcnt_n;
    logic [7:0]          tcnt, tcnt_n;
    logic [3:0]          bcnt, bcnt_n;
    logic                req_lat, req_lat_n;
    logic                timeout_hit;
    logic                chk_bad;

    logic                hold_vld;
    logic [3:0]          hold_addr;
    logic [27:0]         hold_dat;
    logic                wr_vld;
    logic [3:0]          wr_addr;
    logic [27:0]         wr_dat;
    logic                wr_bad;
    logic                wr_clr;

    // A write sampled in COMMIT is delayed one cycle so it lands after the copy.
    always_comb begin
        wr_vld  = hold_vld || (cfg_wr && (state != COMMIT));
        wr_addr = hold_vld ? hold_addr : cfg_addr;
        wr_dat  = hold_vld ? hold_dat  : cfg_wdata;
        wr_clr  = wr_vld && (wr_addr == 4'hF);
        wr_bad  = wr_vld && !((wr_addr == 4'h0) || (wr_addr == 4'hF) ||
                              ((wr_addr >= 4'h1) && (wr_addr <= MASK_TOP)));
    end

    assign chk_bad = (thr_sh[8:6] < thr_sh[5:3]) || (thr_sh[14:12] < thr_sh[11:9]);

    always_comb begin
        state_n     = state;
        qcnt_n      = qcnt;
        tcnt_n      = tcnt;
        bcnt_n      = bcnt;
        req_lat_n   = req_lat;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (apply_req) begin
                    state_n = PENDING;
                    qcnt_n  = 4'd0;
                    tcnt_n  = 8'd0;
                end
            end
            PENDING: begin
                if (!quiet)
                    qcnt_n = 4'd0;
                else if (qcnt != 4'd15)
                    qcnt_n = qcnt + 4'd1;
                tcnt_n = tcnt + 8'd1;
                // Quiet exit takes precedence, so a simultaneous timeout is not flagged.
                if (qcnt_n >= QC)
                    state_n = COMMIT;
                else if (tcnt_n >= TO) begin
                    state_n     = COMMIT;
                    timeout_hit = 1'b1;
                end
            end
            COMMIT: begin
                state_n   = BLANK;
                bcnt_n    = {1'b0, thr_sh[2:0]} + 4'd2;
                req_lat_n = 1'b0;
            end
            BLANK: begin
                bcnt_n = bcnt - 4'd1;
                if (apply_req)
                    req_lat_n = 1'b1;
                if (bcnt == 4'd1) begin
                    req_lat_n = 1'b0;
                    if (req_lat || apply_req) begin
                        state_n = PENDING;
                        qcnt_n  = 4'd0;
                        tcnt_n  = 8'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            qcnt       <= 4'd0;
            tcnt       <= 8'd0;
            bcnt       <= 4'd0;
            req_lat    <= 1'b0;
            apply_busy <= 1'b0;
            apply_done <= 1'b0;
            patt_blank <= 1'b0;
            forced     <= 1'b0;
        end else begin
            state      <= state_n;
            qcnt       <= qcnt_n;
            tcnt       <= tcnt_n;
            bcnt       <= bcnt_n;
            req_lat    <= req_lat_n;
            apply_busy <= (state_n != IDLE);
            patt_blank <= (state_n == BLANK);
            apply_done <= (state_n == BLANK) && (bcnt_n == 4'd1);
            if (timeout_hit)
                forced <= 1'b1;
            else if (apply_req)
                forced <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_sh    <= DEF_THR;
            mask_sh   <= '1;
            thr_act   <= DEF_THR;
            mask_act  <= '1;
            hold_vld  <= 1'b0;
            hold_addr <= 4'd0;
            hold_dat  <= 28'd0;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            hold_vld  <= cfg_wr && ((state == COMMIT) || hold_vld);
            hold_addr <= cfg_addr;
            hold_dat  <= cfg_wdata;
            cfg_ack   <= wr_vld;
            if (wr_vld) begin
                if (wr_addr == 4'h0)
                    thr_sh <= wr_dat[16:0];
                for (int k = 0; k < NMASK; k++)
                    if (wr_addr == 4'(k + 1))
                        mask_sh[28*k +: 28] <= wr_dat;
            end
            if (state == COMMIT) begin
                thr_act  <= thr_sh;
                mask_act <= mask_sh;
            end
            if (wr_bad || ((state == COMMIT) && chk_bad))
                cfg_err <= 1'b1;
            else if (wr_clr)
                cfg_err <= 1'b0;
        end
    end

    assign drifttime   = thr_act[2:0];
    assign pretrig     = thr_act[5:3];
    assign trig        = thr_act[8:6];
    assign acc_pretrig = thr_act[11:9];
    assign acc_trig    = thr_act[14:12];
    assign trig_mode   = thr_act[16:15];
    assign collmask    = mask_act;

endmodule

// File: tb/tb_patterner_cfg_ctrl.sv
// Randomized bench for patterner_cfg_ctrl: stimulus pushes expected acks/commits into queues,
// a negedge monitor pops and compares them whenever the DUT acks or starts a blank window.
module tb_patterner_cfg_ctrl;

    localparam int          NMASK     = 4;
    localparam int          QUIET_CYC = 4;
    localparam int          TIMEOUT   = 255;
    localparam logic [16:0] DEF_THR   = 17'h0_4893;

    logic                clk, rst_n, cfg_wr, cfg_ack, cfg_err;
    logic [3:0]          cfg_addr;
    logic [27:0]         cfg_wdata;
    logic                apply_req, apply_busy, apply_done, quiet, forced, patt_blank;
    logic [2:0]          drifttime, pretrig, trig, acc_pretrig, acc_trig;
    logic [1:0]          trig_mode;
    logic [28*NMASK-1:0] collmask;

    patterner_cfg_ctrl #(.NMASK(NMASK), .QUIET_CYC(QUIET_CYC), .TIMEOUT(TIMEOUT), .DEF_THR(DEF_THR)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .apply_req(apply_req), .apply_busy(apply_busy),
        .apply_done(apply_done), .quiet(quiet), .forced(forced), .patt_blank(patt_blank),
        .drifttime(drifttime), .pretrig(pretrig), .trig(trig), .acc_pretrig(acc_pretrig),
        .acc_trig(acc_trig), .trig_mode(trig_mode), .collmask(collmask)
    );

    typedef struct { int cyc; bit err; } ack_t;
    typedef struct { int cyc; logic [16:0] thr; logic [28*NMASK-1:0] mask; bit frc; bit err; } cmt_t;

    ack_t ack_q[$];
    cmt_t cmt_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit mon_en = 0;

    // Reference model state.
    logic [16:0] sh_thr;
    logic [27:0] sh_mask [NMASK];
    bit          err_m;

    logic [16:0]         cur_thr;
    logic [28*NMASK-1:0] cur_mask;
    logic [16:0]         act_thr;
    int                  blen = 0;
    int                  bcnt = 0;
    bit                  blank_prev = 0;
    ack_t                ak;
    cmt_t                cm;

    assign act_thr = {trig_mode, acc_trig, acc_pretrig, trig, pretrig, drifttime};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [28*NMASK-1:0] flat_mask();
        logic [28*NMASK-1:0] m;
        for (int k = 0; k < NMASK; k++) m[28*k +: 28] = sh_mask[k];
        return m;
    endfunction

    function automatic int blank_len(input logic [16:0] t);
        return int'(t[2:0]) + 2;
    endfunction

    function automatic bit inconsistent(input logic [16:0] t);
        return (t[8:6] < t[5:3]) || (t[14:12] < t[11:9]);
    endfunction

    task automatic model_reset();
        sh_thr = DEF_THR;
        for (int k = 0; k < NMASK; k++) sh_mask[k] = '1;
        err_m    = 0;
        cur_thr  = DEF_THR;
        cur_mask = '1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [27:0] d);
        ack_t it;
        @(negedge clk);
        cfg_wr = 1; cfg_addr = a; cfg_wdata = d;
        if (a == 0) sh_thr = d[16:0];
        else if (a >= 1 && int'(a) <= NMASK) sh_mask[int'(a) - 1] = d;
        else if (a == 4'hF) err_m = 0;
        else err_m = 1;
        it.cyc = cyc + 1; it.err = err_m;
        ack_q.push_back(it);
        @(negedge clk);
        cfg_wr = 0;
    endtask

    // mode 0: quiet always 1, 1: never quiet, 2: random, 3: one dropout at index 3.
    task automatic do_apply(input int mode, input bit wr_commit, input bit latch);
        bit   q[$];
        int   k, run, p, len, start, end_c;
        bit   frc;
        cmt_t it;
        ack_t wa;
        logic [27:0] wd;
        for (int i = 0; i < TIMEOUT; i++)
            q.push_back(mode == 0 || mode == 3 ? 1'b1 : mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0));
        if (mode == 3) q[3] = 1'b0;
        // Commit happens at the first index that completes a quiet run, else at the timeout.
        k = TIMEOUT - 1; frc = 1; run = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            run = q[i] ? run + 1 : 0;
            if (run >= QUIET_CYC) begin k = i; frc = 0; break; end
        end
        @(negedge clk);
        apply_req = 1;
        p = cyc + 1;
        err_m = err_m | inconsistent(sh_thr);
        start = p + k + 2;
        len   = blank_len(sh_thr);
        it.cyc = start; it.thr = sh_thr; it.mask = flat_mask(); it.frc = frc; it.err = err_m;
        cmt_q.push_back(it);
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            apply_req = 0;
            quiet = q[i];
        end
        @(negedge clk);
        if (wr_commit) begin
            wd = 28'($urandom);
            cfg_wr = 1; cfg_addr = 4'h1; cfg_wdata = wd;
            sh_mask[0] = wd;
            wa.cyc = cyc + 2; wa.err = err_m;
            ack_q.push_back(wa);
        end
        @(negedge clk);
        cfg_wr = 0;
        end_c = start + len;
        if (latch) begin
            while (cyc < start + 2) @(negedge clk);
            apply_req = 1;
            err_m = err_m | inconsistent(sh_thr);
            it.cyc = start + len + 5; it.frc = 0; it.err = err_m;
            cmt_q.push_back(it);
            @(negedge clk);
            apply_req = 0;
            end_c = it.cyc + len;
        end
        while (cyc < end_c) @(negedge clk);
    endtask

    task automatic check_defaults(input string tag);
        chk({tag, "_thr"}, act_thr, DEF_THR);
        chk({tag, "_mask"}, collmask, {(28*NMASK){1'b1}});
        chk({tag, "_ack"}, cfg_ack, 0);
        chk({tag, "_err"}, cfg_err, 0);
        chk({tag, "_busy"}, apply_busy, 0);
        chk({tag, "_done"}, apply_done, 0);
        chk({tag, "_forced"}, forced, 0);
        chk({tag, "_blank"}, patt_blank, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (cfg_ack) begin
                chk("ack_expected", ack_q.size() > 0, 1);
                if (ack_q.size() > 0) begin
                    ak = ack_q.pop_front();
                    chk("ack_cycle", cyc, ak.cyc);
                    chk("ack_err", cfg_err, ak.err);
                    chk("active_thr_hold", act_thr, cur_thr);
                    chk("active_mask_hold", collmask, cur_mask);
                end
            end
            if (patt_blank && !blank_prev) begin
                chk("commit_expected", cmt_q.size() > 0, 1);
                if (cmt_q.size() > 0) begin
                    cm = cmt_q.pop_front();
                    chk("commit_cycle", cyc, cm.cyc);
                    chk("commit_thr", act_thr, cm.thr);
                    chk("commit_mask", collmask, cm.mask);
                    chk("commit_forced", forced, cm.frc);
                    chk("commit_err", cfg_err, cm.err);
                    chk("commit_busy", apply_busy, 1);
                    cur_thr  = cm.thr;
                    cur_mask = cm.mask;
                    blen     = blank_len(cm.thr);
                end
                bcnt = 0;
            end
            if (patt_blank) begin
                bcnt++;
                chk("done_position", apply_done, bcnt == blen);
            end else if (apply_done) begin
                chk("done_outside_blank", apply_done, 0);
            end
            if (!patt_blank && blank_prev) chk("blank_length", bcnt, blen);
            blank_prev = patt_blank;
        end
    end

    initial begin
        rst_n = 0; cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0; apply_req = 0; quiet = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_defaults("reset");
        mon_en = 1;

        do_write(4'h0, 28'h0008A45);
        do_write(4'h2, 28'h0FFF000);
        do_apply(0, 0, 0);
        do_apply(1, 0, 0);
        do_apply(3, 0, 0);
        do_write(4'h9, 28'h1234567);
        do_write(4'hF, 28'h0);
        do_apply(0, 1, 0);
        do_write(4'h0, 28'h0004894);
        do_apply(0, 0, 1);

        for (int t = 0; t < 14; t++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                do_write(4'($urandom_range(0, 15)), 28'($urandom));
            do_apply($urandom_range(0, 2), $urandom_range(0, 3) == 0, 0);
        end

        repeat (20) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("commit_queue_drained", cmt_q.size(), 0);

        // Reset in the middle of a pending commit.
        do_write(4'h3, 28'h0ABCDEF);
        @(negedge clk); apply_req = 1; quiet = 0;
        @(negedge clk); apply_req = 0;
        repeat (5) @(negedge clk);
        chk("busy_in_pending", apply_busy, 1);
        mon_en = 0;
        #2 rst_n = 0;
        #1;
        check_defaults("abort");
        ack_q.delete();
        cmt_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        blank_prev = 0;
        mon_en = 1;
        do_apply(0, 0, 0);
        repeat (5) @(negedge clk);
        chk("final_commit_drained", cmt_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
